// File: rtl/node_settle_integrator.sv
// Circuit-node integrator: sums signed branch currents, steps the node voltage by
// sum >>> CAP_SHIFT with rail clamping, and iterates until the node is quiet or times out.
module node_settle_integrator #(
    parameter int W             = 16,
    parameter int N_IN          = 4,
    parameter int CAP_SHIFT     = 2,
    parameter int V_HI          = 16384,
    parameter int V_LO          = -16384,
    parameter int TH_HI         = 4096,
    parameter int TH_LO         = -4096,
    parameter int SETTLE_EPS    = 2,
    parameter int SETTLE_CYCLES = 4,
    parameter int MAX_ITER      = 64
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                init_vld,
    input  logic signed [W-1:0] init_v,
    input  logic [N_IN*W-1:0]   i_in,
    output logic signed [W-1:0] v,
    output logic                q,
    output logic                busy,
    output logic                done,
    output logic                timeout
);
    localparam int SW = W + $clog2(N_IN);
    localparam int XW = SW + 1;
    localparam int W1 = W + 1;
    localparam int IW = $clog2(MAX_ITER + 1);
    localparam int CW = $clog2(SETTLE_CYCLES + 1);

    localparam logic signed [W-1:0]  V_HI_W     = W'(V_HI);
    localparam logic signed [W-1:0]  V_LO_W     = W'(V_LO);
    localparam logic signed [W-1:0]  TH_HI_W    = W'(TH_HI);
    localparam logic signed [W-1:0]  TH_LO_W    = W'(TH_LO);
    localparam logic signed [XW-1:0] V_HI_X     = XW'(V_HI);
    localparam logic signed [XW-1:0] V_LO_X     = XW'(V_LO);
    localparam logic signed [W1-1:0] EPS_P      = W1'(SETTLE_EPS);
    localparam logic signed [W1-1:0] EPS_N      = W1'(-SETTLE_EPS);
    localparam logic [IW-1:0]        ITER_LIM   = IW'(MAX_ITER);
    localparam logic [CW-1:0]        SETTLE_LIM = CW'(SETTLE_CYCLES);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t               state_q;
    logic signed [W-1:0]  v_q;
    logic                 lvl_q;
    logic                 busy_q;
    logic                 done_q;
    logic                 timeout_q;
    logic [IW-1:0]        iter_q;
    logic [CW-1:0]        settle_q;

    logic signed [SW-1:0] branch_ext [N_IN];
    logic signed [SW-1:0] sum_d;
    logic signed [SW-1:0] delta_d;
    logic signed [XW-1:0] v_wide_d;
    logic signed [XW-1:0] v_clamp_d;
    logic signed [W-1:0]  v_d;
    logic signed [W1-1:0] chg_d;
    logic                 quiet_d;
    logic signed [W-1:0]  init_clamp_d;
    logic                 lvl_d;
    logic [IW-1:0]        iter_d;
    logic [CW-1:0]        settle_d;

    for (genvar gi = 0; gi < N_IN; gi++) begin : g_branch
        assign branch_ext[gi] = SW'($signed(i_in[gi*W +: W]));
    end

    // The sum is sized with clog2(N_IN) guard bits, so it never wraps.
    always_comb begin
        sum_d = '0;
        for (int k = 0; k < N_IN; k++) begin
            sum_d = sum_d + branch_ext[k];
        end
    end

    assign delta_d   = sum_d >>> CAP_SHIFT;
    assign v_wide_d  = XW'(v_q) + XW'(delta_d);
    assign v_clamp_d = (v_wide_d > V_HI_X) ? V_HI_X :
                       (v_wide_d < V_LO_X) ? V_LO_X : v_wide_d;
    assign v_d       = v_clamp_d[W-1:0];

    // Quietness is judged on the change actually applied, so a rail-pinned node settles.
    assign chg_d     = W1'(v_d) - W1'(v_q);
    assign quiet_d   = (chg_d <= EPS_P) && (chg_d >= EPS_N);

    assign iter_d    = iter_q + 1'b1;
    assign settle_d  = quiet_d ? settle_q + 1'b1 : '0;

    assign init_clamp_d = (init_v > V_HI_W) ? V_HI_W :
                          (init_v < V_LO_W) ? V_LO_W : init_v;

    assign lvl_d = (v_q >= TH_HI_W) ? 1'b1 :
                   (v_q <= TH_LO_W) ? 1'b0 : lvl_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            v_q       <= V_LO_W;
            lvl_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            timeout_q <= 1'b0;
            iter_q    <= '0;
            settle_q  <= '0;
        end else begin
            lvl_q  <= lvl_d;
            done_q <= 1'b0;
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (init_vld) begin
                        v_q <= init_clamp_d;
                    end
                    if (start) begin
                        state_q   <= S_RUN;
                        busy_q    <= 1'b1;
                        iter_q    <= '0;
                        settle_q  <= '0;
                        timeout_q <= 1'b0;
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                S_RUN: begin
                    v_q      <= v_d;
                    iter_q   <= iter_d;
                    settle_q <= settle_d;
                    // Settling is tested first so it wins over a simultaneous timeout.
                    if (settle_d == SETTLE_LIM) begin
                        state_q   <= S_DONE;
                        busy_q    <= 1'b0;
                        done_q    <= 1'b1;
                        timeout_q <= 1'b0;
                    end else if (iter_d == ITER_LIM) begin
                        state_q   <= S_DONE;
                        busy_q    <= 1'b0;
                        done_q    <= 1'b1;
                        timeout_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign v       = v_q;
    assign q       = lvl_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign timeout = timeout_q;

endmodule
